// File: rtl/md5_round_seq.sv
// md5_round_seq: sweeps the Kt table address and emits per-step MD5 control, delayed to line up with the Kt word
module md5_round_seq #(
  parameter int N_CYCLES   = 72,
  parameter int KT_LATENCY = 2,
  parameter int STEP_OFS   = 4,
  localparam int TW = $clog2(N_CYCLES),
  localparam int CW = $clog2(KT_LATENCY + 1)
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [TW-1:0] t,
  output logic          kt_en,
  output logic          busy,
  output logic          valid,
  output logic [5:0]    step,
  output logic [3:0]    msg_idx,
  output logic [4:0]    shift_amt,
  output logic [1:0]    fn_sel,
  output logic          last,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic       valid;
    logic [5:0] step;
    logic [3:0] msg_idx;
    logic [4:0] shift_amt;
    logic [1:0] fn_sel;
    logic       last;
  } ctl_t;
  localparam logic [4:0] SH [16] = '{5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
                                     5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21};
  state_t                   state_q, state_d;
  logic [TW-1:0]            t_q, t_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     kt_en_q, kt_en_d, busy_q, busy_d, done_q, done_d;
  ctl_t                     dec;
  ctl_t [KT_LATENCY-1:0]    dl_q, dl_d;
  logic [5:0]               s;
  logic                     in_rng;
  // all state and registered outputs; abort and reset both land here
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      cnt_q   <= '0;
      kt_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      kt_en_q <= kt_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dl_q    <= dl_d;
    end
  end
  // next state: abort always returns to idle, drain lasts KT_LATENCY cycles
  always_comb begin
    state_d = abort ? IDLE :
              state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (t_q == TW'(N_CYCLES - 1) ? DRAIN : RUN) :
              (cnt_q == CW'(KT_LATENCY - 1) ? IDLE : DRAIN);
  end
  // registered outputs derived from the state being entered
  always_comb begin
    t_d     = state_d == DRAIN ? t_q :
              (state_d == RUN && state_q == RUN) ? t_q + TW'(1) : '0;
    kt_en_d = state_d == RUN;
    busy_d  = state_d != IDLE;
    done_d  = state_q == DRAIN && state_d == IDLE && !abort;
    cnt_d   = (state_q == DRAIN && state_d == DRAIN) ? cnt_q + CW'(1) : '0;
  end
  // decode of the slot currently presented to the BRAM, zero on padding slots
  always_comb begin
    s      = 6'(t_q - TW'(STEP_OFS));
    in_rng = kt_en_q && t_q >= TW'(STEP_OFS) && t_q < TW'(STEP_OFS + 64);
    dec    = '0;
    if (in_rng) begin
      dec.valid     = 1'b1;
      dec.step      = s;
      dec.fn_sel    = s[5:4];
      dec.last      = s == 6'd63;
      dec.shift_amt = SH[{s[5:4], s[1:0]}];
      dec.msg_idx   = s[5:4] == 2'd0 ? s[3:0] :
                      s[5:4] == 2'd1 ? s[3:0] * 4'd5 + 4'd1 :
                      s[5:4] == 2'd2 ? s[3:0] * 4'd3 + 4'd5 : s[3:0] * 4'd7;
    end
  end
  // delay line: first stage captures the decode, abort flushes everything
  always_comb begin
    dl_d = abort ? '0 : {dl_q[KT_LATENCY-2:0], dec};
  end
  assign t         = t_q;
  assign kt_en     = kt_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = dl_q[KT_LATENCY-1].valid;
  assign step      = dl_q[KT_LATENCY-1].step;
  assign msg_idx   = dl_q[KT_LATENCY-1].msg_idx;
  assign shift_amt = dl_q[KT_LATENCY-1].shift_amt;
  assign fn_sel    = dl_q[KT_LATENCY-1].fn_sel;
  assign last      = dl_q[KT_LATENCY-1].last;
endmodule

// File: tb/tb_md5_round_seq.sv
// tb_md5_round_seq: timeline-model checks of md5_round_seq with a Kt BRAM model attached
module tb_md5_round_seq;
  typedef struct packed {
    logic [6:0] t;
    logic       kt_en, busy, valid;
    logic [5:0] step;
    logic [3:0] msg;
    logic [4:0] sh;
    logic [1:0] fn;
    logic       last, done;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [6:0] t;
  logic kt_en, busy, valid, last, done;
  logic [5:0] step;
  logic [3:0] msg_idx;
  logic [4:0] shift_amt;
  logic [1:0] fn_sel;
  obs_t obs;
  logic [31:0] rom [72];
  logic [31:0] bram_q = '0, kt_q = '0;
  int vec = 0, miss = 0;
  int shtab [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
  md5_round_seq dut (.CLK(clk), .rst_n(rst_n), .start(start), .abort(abort), .t(t), .kt_en(kt_en),
                     .busy(busy), .valid(valid), .step(step), .msg_idx(msg_idx), .shift_amt(shift_amt),
                     .fn_sel(fn_sel), .last(last), .done(done));
  assign obs = {t, kt_en, busy, valid, step, msg_idx, shift_amt, fn_sel, last, done};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (kt_en) bram_q <= rom[t];
    kt_q <= bram_q;
  end
  // expected outputs in cycle E+k of a sweep whose start was sampled at edge E
  function automatic obs_t model(int k);
    obs_t o = '0;
    int s, r;
    if (k >= 1 && k <= 72) begin o.t = 7'(k - 1); o.kt_en = 1'b1; end
    else if (k == 73 || k == 74) o.t = 7'd71;
    o.busy = k >= 1 && k <= 74;
    o.done = k == 75;
    if (k >= 7 && k <= 70) begin
      s = k - 7;
      r = s / 16;
      o.valid = 1'b1;
      o.step  = 6'(s);
      o.fn    = 2'(r);
      o.last  = s == 63;
      o.sh    = 5'(shtab[r][s % 4]);
      o.msg   = r == 0 ? 4'(s % 16) : r == 1 ? 4'((5 * s + 1) % 16) :
                r == 2 ? 4'((3 * s + 5) % 16) : 4'((7 * s) % 16);
    end
    return o;
  endfunction
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    vec++; if (obs !== '0) begin miss++; $display("FAIL reset got %h exp %h", obs, 29'h0); end
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if (obs !== '0) begin miss++; $display("FAIL reset_idle got %h exp %h", obs, 29'h0); end
  endtask
  task automatic test_sweep(input bit noise);
    obs_t ex;
    logic [31:0] kexp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 76; k++) begin
      ex = model(k);
      vec++; if (obs !== ex) begin miss++; $display("FAIL sweep k=%0d got %h exp %h", k, obs, ex); end
      if (k >= 3) begin
        kexp = ex.valid ? rom[int'(ex.step) + 4] : 32'h0;
        vec++; if (kt_q !== kexp) begin miss++; $display("FAIL sweep_kt k=%0d got %h exp %h", k, kt_q, kexp); end
      end
      start = (noise && k <= 74) ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic test_decode();
    int ss [5] = '{0, 16, 32, 48, 63};
    int em [5] = '{0, 1, 5, 0, 9};
    int es [5] = '{7, 5, 4, 6, 21};
    int ef [5] = '{0, 1, 2, 3, 3};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 76; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (k == 7 + ss[i]) begin
          vec++;
          if (valid !== 1'b1 || step !== 6'(ss[i]) || msg_idx !== 4'(em[i]) || shift_amt !== 5'(es[i]) ||
              fn_sel !== 2'(ef[i]) || last !== (i == 4)) begin
            miss++;
            $display("FAIL decode s=%0d got v%b msg %0d sh %0d fn %0d last %b exp v1 msg %0d sh %0d fn %0d last %b",
                     ss[i], valid, msg_idx, shift_amt, fn_sel, last, em[i], es[i], ef[i], i == 4);
          end
        end
      end
      if (k == 7) begin vec++; if (kt_q !== 32'hd76aa478) begin miss++; $display("FAIL kt_s0 got %h exp d76aa478", kt_q); end end
      if (k == 70) begin vec++; if (kt_q !== 32'heb86d391) begin miss++; $display("FAIL kt_s63 got %h exp eb86d391", kt_q); end end
      @(negedge clk);
    end
  endtask
  task automatic test_abort(input int k_ab);
    obs_t ex;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= k_ab; k++) begin
      ex = model(k);
      vec++; if (obs !== ex) begin miss++; $display("FAIL abort_pre k=%0d got %h exp %h", k, obs, ex); end
      abort = k == k_ab;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      vec++; if (obs !== '0) begin miss++; $display("FAIL abort_post at=%0d k=%0d got %h exp %h", k_ab, k, obs, 29'h0); end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    obs_t ex;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 225; k++) begin
      ex = model(((k - 1) % 75) + 1);
      vec++; if (obs !== ex) begin miss++; $display("FAIL b2b k=%0d got %h exp %h", k, obs, ex); end
      start = k < 225;
      @(negedge clk);
    end
    vec++; if (obs !== '0) begin miss++; $display("FAIL b2b_end got %h exp %h", obs, 29'h0); end
    start = 1'b1; abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vec++; if (obs !== '0) begin miss++; $display("FAIL start_abort k=%0d got %h exp %h", k, obs, 29'h0); end
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_async_reset(input int k_rst);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k_rst - 1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vec++; if (obs !== '0) begin miss++; $display("FAIL async_rst k=%0d got %h exp %h", k_rst, obs, 29'h0); end
    @(negedge clk);
    vec++; if (obs !== '0) begin miss++; $display("FAIL async_rst_hold got %h exp %h", obs, 29'h0); end
    rst_n = 1'b1;
    @(negedge clk);
    test_sweep(1'b0);
  endtask
  initial begin
    for (int i = 0; i < 72; i++) begin
      real v;
      v = $sin(real'(i - 3));
      v = v < 0.0 ? -v : v;
      rom[i] = (i >= 4 && i < 68) ? 32'(longint'($floor(v * 4294967296.0))) : 32'h0;
    end
    test_reset();
    test_sweep(1'b0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    test_sweep(1'b1);
    test_decode();
    test_abort(30);
    test_sweep(1'b0);
    test_abort($urandom_range(1, 74));
    test_sweep(1'b1);
    test_back_to_back();
    test_async_reset($urandom_range(2, 60));
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
